// File: rtl/async_fifo_pkg.sv
// Shared defaults and the address-width helper for the single-clock FIFO.
package async_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Smallest w with 2**w >= depth; usable in constant expressions.
  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// FIFO storage: one synchronous write port, one registered read port with enable.
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AW         = addr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Array is deliberately left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO top: pointers, full/empty flags and optional occupancy.
// Define ASYNC_FIFO_COUNT_EN to add the o_count occupancy output.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int AW         = addr_width(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
`ifdef ASYNC_FIFO_COUNT_EN
  output logic                  o_empty,
  output logic [AW:0]           o_count
`else
  output logic                  o_empty
`endif
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr_reg, wptr_next;
  logic [AW:0] rptr_reg, rptr_next;
  logic        wr_accept;
  logic        rd_accept;

  // Enables are gated by reset so a reset cycle never touches memory or read data.
  assign wr_accept = i_rst_n && i_wr_en && !o_full;
  assign rd_accept = i_rst_n && i_rd_en && !o_empty;

  always_comb begin
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    if (wr_accept) wptr_next = wptr_reg + PTR_ONE;
    if (rd_accept) rptr_next = rptr_reg + PTR_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
    end
  end

  // The extra wrap bit distinguishes full from empty when addresses match.
  assign o_empty = (wptr_reg == rptr_reg);
  assign o_full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);

`ifdef ASYNC_FIFO_COUNT_EN
  assign o_count = wptr_reg - rptr_reg;
`endif

  async_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wptr_reg[AW-1:0]),
    .wr_data (i_wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rptr_reg[AW-1:0]),
    .rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo (default 4-bit x 8 configuration).
module tb_async_fifo;

  localparam int DW = 4;
  localparam int DEPTH = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_wr_en;
  logic [DW-1:0] i_wr_data;
  logic          i_rd_en;
  logic [DW-1:0] o_rd_data;
  logic          o_full;
  logic          o_empty;
`ifdef ASYNC_FIFO_COUNT_EN
  logic [3:0]    o_count;
`endif

  int total = 0;
  int bad = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_rd;

  always #5 i_clk = ~i_clk;

  async_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (i_wr_en),
    .i_wr_data (i_wr_data),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rd_data),
    .o_full    (o_full),
`ifdef ASYNC_FIFO_COUNT_EN
    .o_empty   (o_empty),
    .o_count   (o_count)
`else
    .o_empty   (o_empty)
`endif
  );

  // One clock with the given requests; the model is updated from pre-edge occupancy.
  task automatic cyc(input logic wr, input logic [DW-1:0] d, input logic rd);
    logic wacc, racc;
    wacc = wr && (sb.size() < DEPTH);
    racc = rd && (sb.size() != 0);
    i_wr_en = wr;
    i_wr_data = d;
    i_rd_en = rd;
    @(posedge i_clk);
    #1;
    if (racc) exp_rd = sb.pop_front();
    if (wacc) sb.push_back(d);
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    $display("cyc wr=%0b d=%0d rd=%0b -> rd_data=%0d full=%0b empty=%0b", wr, d, rd,
             o_rd_data, o_full, o_empty);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    sb.delete();
    exp_rd = '0;
    total++;
    if (o_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_empty got=%0b want=1", o_empty);
    end
    total++;
    if (o_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_full got=%0b want=0", o_full);
    end
    total++;
    if (o_rd_data !== 4'd0) begin
      bad++;
      $display("FAIL reset_rd_data got=%0d want=0", o_rd_data);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 4'(i + 2), 1'b0);
      total++;
      if (o_full !== (i == DEPTH - 1) || o_empty !== 1'b0) begin
        bad++;
        $display("FAIL fill_flags i=%0d got full=%0b empty=%0b want full=%0b empty=0",
                 i, o_full, o_empty, (i == DEPTH - 1));
      end
    end
    cyc(1'b1, 4'd15, 1'b0);
    total++;
    if (o_full !== 1'b1 || sb.size() != DEPTH) begin
      bad++;
      $display("FAIL fill_drop got full=%0b want=1", o_full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 4'd0, 1'b1);
      total++;
      if (o_rd_data !== exp_rd) begin
        bad++;
        $display("FAIL drain_data i=%0d got=%0d want=%0d", i, o_rd_data, exp_rd);
      end
    end
    total++;
    if (o_empty !== 1'b1 || o_full !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty got empty=%0b full=%0b want empty=1 full=0", o_empty, o_full);
    end
    cyc(1'b0, 4'd0, 1'b1);
    total++;
    if (o_rd_data !== 4'd9) begin
      bad++;
      $display("FAIL drain_hold got=%0d want=9", o_rd_data);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'd0, 1'b1);
      total++;
      if (o_rd_data !== exp_rd) begin
        bad++;
        $display("FAIL wrap_pre i=%0d got=%0d want=%0d", i, o_rd_data, exp_rd);
      end
    end
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(15 - i), 1'b0);
    total++;
    if (o_full !== 1'b1) begin
      bad++;
      $display("FAIL wrap_full got=%0b want=1", o_full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 4'd0, 1'b1);
      total++;
      if (o_rd_data !== exp_rd) begin
        bad++;
        $display("FAIL wrap_data i=%0d got=%0d want=%0d", i, o_rd_data, exp_rd);
      end
    end
    total++;
    if (o_empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_empty got=%0b want=1", o_empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 1), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 4'($urandom_range(0, 15)), 1'b1);
      total++;
      if (o_rd_data !== exp_rd || o_empty !== 1'b0 || o_full !== 1'b0) begin
        bad++;
        $display("FAIL simul i=%0d got data=%0d empty=%0b full=%0b want data=%0d empty=0 full=0",
                 i, o_rd_data, o_empty, o_full, exp_rd);
      end
`ifdef ASYNC_FIFO_COUNT_EN
      total++;
      if (o_count !== 4'd4) begin
        bad++;
        $display("FAIL simul_count i=%0d got=%0d want=4", i, o_count);
      end
`endif
    end
  endtask

  task automatic test_boundary();
    // Drain to empty, then write+read on empty: only the write lands.
    while (sb.size() != 0) cyc(1'b0, 4'd0, 1'b1);
    cyc(1'b1, 4'd6, 1'b1);
    total++;
    if (o_empty !== 1'b0 || o_rd_data !== exp_rd) begin
      bad++;
      $display("FAIL empty_rw got empty=%0b data=%0d want empty=0 data=%0d",
               o_empty, o_rd_data, exp_rd);
    end
    // Fill, then write+read on full: only the read lands.
    while (sb.size() < DEPTH) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    cyc(1'b1, 4'd13, 1'b1);
    total++;
    if (o_full !== 1'b0 || o_rd_data !== 4'd6) begin
      bad++;
      $display("FAIL full_rw got full=%0b data=%0d want full=0 data=6", o_full, o_rd_data);
    end
    while (sb.size() > 3) begin
      cyc(1'b0, 4'd0, 1'b1);
      total++;
      if (o_rd_data !== exp_rd) begin
        bad++;
        $display("FAIL bound_data got=%0d want=%0d", o_rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_mid_reset();
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    sb.delete();
    exp_rd = '0;
    i_rst_n = 1'b1;
    total++;
    if (o_empty !== 1'b1 || o_rd_data !== 4'd0) begin
      bad++;
      $display("FAIL midrst got empty=%0b data=%0d want empty=1 data=0", o_empty, o_rd_data);
    end
    cyc(1'b0, 4'd0, 1'b1);
    total++;
    if (o_empty !== 1'b1 || o_rd_data !== 4'd0) begin
      bad++;
      $display("FAIL midrst_read got empty=%0b data=%0d want empty=1 data=0", o_empty, o_rd_data);
    end
`ifdef ASYNC_FIFO_COUNT_EN
    total++;
    if (o_count !== 4'd0) begin
      bad++;
      $display("FAIL midrst_count got=%0d want=0", o_count);
    end
`endif
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_wr_en = 1'b0;
    i_wr_data = '0;
    i_rd_en = 1'b0;
    exp_rd = '0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_boundary();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
